// File: rtl/dm_resp_pkg.sv
// dm_resp_pkg: shared constants, size encoding and FSM states
// for the data-memory block responder.
package dm_resp_pkg;

  localparam int BLOCK_BITS      = 256;
  localparam int WORD_BITS       = 32;
  localparam int WORDS_PER_BLOCK = 8;

  // Write-size encoding: byte count, with 0 standing for a full word.
  localparam logic [1:0] SZ_4 = 2'd0;
  localparam logic [1:0] SZ_1 = 2'd1;
  localparam logic [1:0] SZ_2 = 2'd2;
  localparam logic [1:0] SZ_3 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_DROP = 2'd3
  } dm_state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    return (sz == SZ_4) ? 3'd4 : {1'b0, sz};
  endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// dm_byte_merge: places n bytes of new data at a byte offset
// inside an old word; lanes past byte 3 are dropped.
module dm_byte_merge
  import dm_resp_pkg::*;
(
  input  logic [WORD_BITS-1:0] old_word,
  input  logic [WORD_BITS-1:0] new_data,
  input  logic [1:0]           offset,
  input  logic [1:0]           size,
  output logic [WORD_BITS-1:0] merged
);

  int o;
  int n;
  int k;

  // Lane L takes source byte L-offset when that byte is in range.
  always_comb begin
    merged = old_word;
    o      = int'(offset);
    n      = int'(size_bytes(size));
    k      = 0;
    for (int lane = 0; lane < 4; lane++) begin
      k = lane - o;
      if (k >= 0 && k < n) begin
        merged[lane*8 +: 8] = new_data[k*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dm_block_responder.sv
// dm_block_responder: word port plus fixed-latency 256-bit block port.
// Optional DMRESP_BOUNDS_CHECK_EN: out-of-range detection and err_oor.
module dm_block_responder
  import dm_resp_pkg::*;
#(
  parameter int DEPTH_BLOCKS = 64,
  parameter int LATENCY      = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           data_address_2DM,
  input  logic                  MemRead_2DM,
  input  logic                  MemWrite_2DM,
  input  logic [WORD_BITS-1:0]  data_write_2DM,
  input  logic [1:0]            data_write_size_2DM,
  output logic [WORD_BITS-1:0]  data_read_fDM,
  input  logic                  dBlkRead,
  input  logic                  dBlkWrite,
  input  logic [BLOCK_BITS-1:0] block_write_2DM,
  output logic [BLOCK_BITS-1:0] block_read_fDM,
  output logic                  block_read_fDM_valid,
  output logic                  block_write_fDM_valid,
  output logic                  err_oor
);

  localparam int IDX_W  = $clog2(DEPTH_BLOCKS);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int NWORDS = DEPTH_BLOCKS * WORDS_PER_BLOCK;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  logic [WORD_BITS-1:0] mem [NWORDS];

  logic [26:0]          w_blk;
  logic [IDX_W-1:0]     w_idx;
  logic [2:0]           w_sel;
  logic [IDX_W+2:0]     w_addr;
  logic                 w_oor;
  logic                 word_we;
  logic [WORD_BITS-1:0] merge_old;
  logic [WORD_BITS-1:0] merged;

  dm_state_t             state;
  logic [CNT_W-1:0]      cnt;
  logic                  op_wr;
  logic [26:0]           b_blk;
  logic [IDX_W-1:0]      b_idx;
  logic [BLOCK_BITS-1:0] b_data;
  logic                  b_oor;
  logic                  commit;
  logic                  blk_we;
  logic                  blk_re;
  logic                  collide;
  logic [BLOCK_BITS-1:0] rd_data;

  assign w_blk  = data_address_2DM[31:5];
  assign w_idx  = w_blk[IDX_W-1:0];
  assign w_sel  = data_address_2DM[4:2];
  assign w_addr = {w_idx, w_sel};
  assign b_idx  = b_blk[IDX_W-1:0];

`ifdef DMRESP_BOUNDS_CHECK_EN
  assign w_oor = (w_blk >> IDX_W) != 27'd0;
  assign b_oor = (b_blk >> IDX_W) != 27'd0;

  // Sticky flag for any out-of-range word access or accepted block request.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      err_oor <= 1'b0;
    end else if (((MemRead_2DM || MemWrite_2DM) && w_oor) ||
                 (state == ST_IDLE && (dBlkWrite || dBlkRead) && w_oor)) begin
      err_oor <= 1'b1;
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^{w_blk[26:IDX_W], b_blk[26:IDX_W]};
  assign w_oor     = 1'b0;
  assign b_oor     = 1'b0;
  assign err_oor   = 1'b0;
`endif

  assign word_we = MemWrite_2DM && RESET && !w_oor;
  assign commit  = (state == ST_BUSY) && (cnt == '0);
  assign blk_we  = commit && op_wr && !b_oor;
  assign blk_re  = commit && !op_wr;
  assign collide = blk_we && word_we && (w_idx == b_idx);

  // On a same-block collision the word write merges over the incoming block data.
  assign merge_old = collide ? b_data[w_sel*WORD_BITS +: WORD_BITS]
                             : mem[w_addr];

  dm_byte_merge u_merge (
    .old_word (merge_old),
    .new_data (data_write_2DM),
    .offset   (data_address_2DM[1:0]),
    .size     (data_write_size_2DM),
    .merged   (merged)
  );

  assign data_read_fDM = (MemRead_2DM && RESET && !w_oor) ? mem[w_addr] : '0;

  // Gather the latched block from the array; out-of-range reads give zero.
  always_comb begin
    rd_data = '0;
    for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
      rd_data[w*WORD_BITS +: WORD_BITS] = b_oor ? '0 : mem[{b_idx, w[2:0]}];
    end
  end

  // Storage array: block commit first, word write last so it wins overlaps.
  always_ff @(posedge CLK) begin
    if (blk_we) begin
      for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
        mem[{b_idx, w[2:0]}] <= b_data[w*WORD_BITS +: WORD_BITS];
      end
    end
    if (word_we) begin
      mem[w_addr] <= merged;
    end
  end

  // Block request FSM: accept, count down, complete, wait for request drop.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      op_wr          <= 1'b0;
      b_blk          <= '0;
      b_data         <= '0;
      block_read_fDM <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (dBlkWrite || dBlkRead) begin
            op_wr  <= dBlkWrite;
            b_blk  <= w_blk;
            b_data <= block_write_2DM;
            cnt    <= CNT_INIT;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            state <= ST_DONE;
            if (blk_re) begin
              block_read_fDM <= rd_data;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_DROP;
        end
        ST_DROP: begin
          if (!(op_wr ? dBlkWrite : dBlkRead)) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign block_read_fDM_valid  = (state == ST_DONE) && !op_wr;
  assign block_write_fDM_valid = (state == ST_DONE) && op_wr;

endmodule

// File: tb/tb_dm_block_responder.sv
// tb_dm_block_responder: scoreboard-driven checks of the word port,
// block FSM timing, priority, collisions, reset abort and range handling.
module tb_dm_block_responder;

  localparam int LAT   = 4;
  localparam int DEPTH = 64;

  logic         CLK;
  logic         RESET;
  logic [31:0]  data_address_2DM;
  logic         MemRead_2DM;
  logic         MemWrite_2DM;
  logic [31:0]  data_write_2DM;
  logic [1:0]   data_write_size_2DM;
  logic [31:0]  data_read_fDM;
  logic         dBlkRead;
  logic         dBlkWrite;
  logic [255:0] block_write_2DM;
  logic [255:0] block_read_fDM;
  logic         block_read_fDM_valid;
  logic         block_write_fDM_valid;
  logic         err_oor;

  int checks = 0;
  int errors = 0;

  logic [31:0]  exp_word[$];
  logic [255:0] exp_blk[$];

  dm_block_responder #(
    .DEPTH_BLOCKS (DEPTH),
    .LATENCY      (LAT)
  ) dut (
    .CLK                   (CLK),
    .RESET                 (RESET),
    .data_address_2DM      (data_address_2DM),
    .MemRead_2DM           (MemRead_2DM),
    .MemWrite_2DM          (MemWrite_2DM),
    .data_write_2DM        (data_write_2DM),
    .data_write_size_2DM   (data_write_size_2DM),
    .data_read_fDM         (data_read_fDM),
    .dBlkRead              (dBlkRead),
    .dBlkWrite             (dBlkWrite),
    .block_write_2DM       (block_write_2DM),
    .block_read_fDM        (block_read_fDM),
    .block_read_fDM_valid  (block_read_fDM_valid),
    .block_write_fDM_valid (block_write_fDM_valid),
    .err_oor               (err_oor)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic wr_word(input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz);
    @(negedge CLK);
    data_address_2DM    = a;
    data_write_2DM      = d;
    data_write_size_2DM = sz;
    MemWrite_2DM        = 1'b1;
    @(negedge CLK);
    MemWrite_2DM        = 1'b0;
  endtask

  task automatic rd_word(input logic [31:0] a, output logic [31:0] v);
    @(negedge CLK);
    data_address_2DM = a;
    MemRead_2DM      = 1'b1;
    #1 v = data_read_fDM;
    #1 MemRead_2DM   = 1'b0;
  endtask

  // Called at a negedge with the request already driven; n is the number of
  // edges after the accepting edge until the pulse is seen, -1 on timeout.
  task automatic wait_pulse(input bit wr, output int n);
    n = -1;
    @(posedge CLK);
    for (int i = 0; i <= 20; i++) begin
      @(negedge CLK);
      if ((wr ? block_write_fDM_valid : block_read_fDM_valid) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    RESET               = 1'b0;
    data_address_2DM    = 32'h40;
    MemRead_2DM         = 1'b1;
    MemWrite_2DM        = 1'b0;
    data_write_2DM      = '0;
    data_write_size_2DM = 2'd0;
    dBlkRead            = 1'b0;
    dBlkWrite           = 1'b0;
    block_write_2DM     = '0;
    repeat (2) @(negedge CLK);
    checks++;
    if (data_read_fDM !== 32'h0) begin
      errors++; $display("FAIL rst_read: got %h want 0", data_read_fDM);
    end
    checks++;
    if (block_read_fDM_valid !== 1'b0 || block_write_fDM_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got %b%b want 00",
               block_read_fDM_valid, block_write_fDM_valid);
    end
    checks++;
    if (block_read_fDM !== '0) begin
      errors++; $display("FAIL rst_blk: got %h want 0", block_read_fDM);
    end
    checks++;
    if (err_oor !== 1'b0) begin
      errors++; $display("FAIL rst_err: got %b want 0", err_oor);
    end
    RESET       = 1'b1;
    MemRead_2DM = 1'b0;
    @(negedge CLK);
    checks++;
    if (data_read_fDM !== 32'h0) begin
      errors++; $display("FAIL rel_read_gated: got %h want 0", data_read_fDM);
    end
  endtask

  task automatic test_word;
    logic [31:0] v, e;
    wr_word(32'h40, 32'hAABBCCDD, 2'd0);
    exp_word.push_back(32'hAABBCCDD);
    rd_word(32'h40, v); e = exp_word.pop_front(); checks++;
    if (v !== e) begin errors++; $display("FAIL word_full: got %h want %h", v, e); end

    wr_word(32'h42, 32'h00000011, 2'd1);
    exp_word.push_back(32'hAA11CCDD);
    rd_word(32'h40, v); e = exp_word.pop_front(); checks++;
    if (v !== e) begin errors++; $display("FAIL word_b1: got %h want %h", v, e); end

    wr_word(32'h44, 32'h0, 2'd0);
    wr_word(32'h45, 32'h00123456, 2'd3);
    exp_word.push_back(32'h12345600);
    rd_word(32'h44, v); e = exp_word.pop_front(); checks++;
    if (v !== e) begin errors++; $display("FAIL word_b3: got %h want %h", v, e); end

    wr_word(32'h48, 32'h0, 2'd0);
    wr_word(32'h4C, 32'h01020304, 2'd0);
    wr_word(32'h4B, 32'h00005566, 2'd2);
    exp_word.push_back(32'h66000000);
    exp_word.push_back(32'h01020304);
    rd_word(32'h48, v); e = exp_word.pop_front(); checks++;
    if (v !== e) begin errors++; $display("FAIL word_edge: got %h want %h", v, e); end
    rd_word(32'h4C, v); e = exp_word.pop_front(); checks++;
    if (v !== e) begin errors++; $display("FAIL word_nocross: got %h want %h", v, e); end

    @(negedge CLK);
    data_address_2DM = 32'h40;
    MemRead_2DM      = 1'b0;
    #1 checks++;
    if (data_read_fDM !== 32'h0) begin
      errors++; $display("FAIL word_rd_off: got %h want 0", data_read_fDM);
    end
  endtask

  task automatic test_block_read;
    logic [255:0] e;
    int n, extra;
    @(negedge CLK);
    data_address_2DM = 32'h40;
    dBlkRead         = 1'b1;
    e = '0;
    e[127:0] = {32'h01020304, 32'h66000000, 32'h12345600, 32'hAA11CCDD};
    exp_blk.push_back(e);
    wait_pulse(1'b0, n);
    checks++;
    if (n !== LAT) begin errors++; $display("FAIL blkrd_lat: got %0d want %0d", n, LAT); end
    e = exp_blk.pop_front();
    checks++;
    if (block_read_fDM[127:0] !== e[127:0]) begin
      errors++;
      $display("FAIL blkrd_data: got %h want %h", block_read_fDM[127:0], e[127:0]);
    end
    extra = 0;
    repeat (3) begin
      @(negedge CLK);
      if (block_read_fDM_valid === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL blkrd_once: got %0d want 0", extra); end
    dBlkRead = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_back_to_back;
    logic [255:0] d, e;
    logic [31:0]  v, ew;
    int n;
    for (int w = 0; w < 8; w++) d[w*32 +: 32] = 32'hB0000000 + 32'(w);
    @(negedge CLK);
    data_address_2DM = 32'h60;
    block_write_2DM  = d;
    dBlkWrite        = 1'b1;
    dBlkRead         = 1'b1;
    exp_blk.push_back(d);
    wait_pulse(1'b1, n);
    checks++;
    if (n !== LAT) begin errors++; $display("FAIL prio_wr_lat: got %0d want %0d", n, LAT); end
    checks++;
    if (block_read_fDM_valid !== 1'b0) begin
      errors++; $display("FAIL prio_rd_first: got %b want 0", block_read_fDM_valid);
    end
    dBlkWrite = 1'b0;
    wait_pulse(1'b0, n);
    checks++;
    if (n !== LAT + 2) begin
      errors++; $display("FAIL prio_rd_lat: got %0d want %0d", n, LAT + 2);
    end
    e = exp_blk.pop_front();
    checks++;
    if (block_read_fDM !== e) begin
      errors++; $display("FAIL prio_rd_data: got %h want %h", block_read_fDM, e);
    end
    dBlkRead = 1'b0;
    repeat (2) @(negedge CLK);
    exp_word.push_back(32'hB0000005);
    rd_word(32'h74, v); ew = exp_word.pop_front(); checks++;
    if (v !== ew) begin errors++; $display("FAIL prio_word: got %h want %h", v, ew); end
  endtask

  task automatic test_collision;
    logic [31:0] v, e;
    @(negedge CLK);
    data_address_2DM = 32'h80;
    block_write_2DM  = '0;
    dBlkWrite        = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    dBlkWrite = 1'b0;
    repeat (LAT - 1) @(posedge CLK);
    @(negedge CLK);
    data_address_2DM    = 32'h80;
    data_write_2DM      = 32'h000000FF;
    data_write_size_2DM = 2'd1;
    MemWrite_2DM        = 1'b1;
    exp_word.push_back(32'h000000FF);
    exp_word.push_back(32'h00000000);
    @(posedge CLK);
    @(negedge CLK);
    MemWrite_2DM = 1'b0;
    checks++;
    if (block_write_fDM_valid !== 1'b1) begin
      errors++; $display("FAIL coll_valid: got %b want 1", block_write_fDM_valid);
    end
    repeat (2) @(negedge CLK);
    rd_word(32'h80, v); e = exp_word.pop_front(); checks++;
    if (v !== e) begin errors++; $display("FAIL coll_word: got %h want %h", v, e); end
    rd_word(32'h84, v); e = exp_word.pop_front(); checks++;
    if (v !== e) begin errors++; $display("FAIL coll_other: got %h want %h", v, e); end
  endtask

  task automatic test_reset_abort;
    logic [31:0]  v, ew;
    logic [255:0] e;
    int pulses, n;
    wr_word(32'hA0, 32'h12345678, 2'd0);
    exp_word.push_back(32'h12345678);
    @(negedge CLK);
    data_address_2DM = 32'hA0;
    block_write_2DM  = '1;
    dBlkWrite        = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET     = 1'b0;
    dBlkWrite = 1'b0;
    pulses = 0;
    repeat (2) begin
      @(negedge CLK);
      if (block_write_fDM_valid === 1'b1 || block_read_fDM_valid === 1'b1) pulses++;
    end
    RESET = 1'b1;
    repeat (LAT + 2) begin
      @(negedge CLK);
      if (block_write_fDM_valid === 1'b1 || block_read_fDM_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL abort_pulse: got %0d want 0", pulses); end
    checks++;
    if (block_read_fDM !== '0) begin
      errors++; $display("FAIL abort_blk_rst: got %h want 0", block_read_fDM);
    end
    checks++;
    if (err_oor !== 1'b0) begin errors++; $display("FAIL abort_err: got %b want 0", err_oor); end
    rd_word(32'hA0, v); ew = exp_word.pop_front(); checks++;
    if (v !== ew) begin errors++; $display("FAIL abort_array: got %h want %h", v, ew); end
    @(negedge CLK);
    data_address_2DM = 32'hA0;
    dBlkRead         = 1'b1;
    e = '0;
    e[31:0] = 32'h12345678;
    exp_blk.push_back(e);
    wait_pulse(1'b0, n);
    checks++;
    if (n !== LAT) begin errors++; $display("FAIL abort_idle: got %0d want %0d", n, LAT); end
    e = exp_blk.pop_front();
    checks++;
    if (block_read_fDM[31:0] !== e[31:0]) begin
      errors++; $display("FAIL abort_rd: got %h want %h", block_read_fDM[31:0], e[31:0]);
    end
    dBlkRead = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_oor;
    logic [31:0] v, e;
    logic        exp_err;
    wr_word(32'h00, 32'hCAFEF00D, 2'd0);
`ifdef DMRESP_BOUNDS_CHECK_EN
    exp_word.push_back(32'h0);
    exp_err = 1'b1;
`else
    exp_word.push_back(32'hCAFEF00D);
    exp_err = 1'b0;
`endif
    rd_word(32'(DEPTH * 32), v); e = exp_word.pop_front(); checks++;
    if (v !== e) begin errors++; $display("FAIL oor_read: got %h want %h", v, e); end
    @(negedge CLK);
    checks++;
    if (err_oor !== exp_err) begin
      errors++; $display("FAIL oor_flag: got %b want %b", err_oor, exp_err);
    end
  endtask

  initial begin
    test_reset;
    test_word;
    test_block_read;
    test_back_to_back;
    test_collision;
    test_reset_abort;
    test_oor;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
